// File: rtl/qrd_pkg.sv
// Shared types and constants for the 4x4 complex QRD core, its input feeder and bench.
package qrd_pkg;

    localparam int IN_W       = 14;
    localparam int FRAC_BITS  = 10;
    localparam int ONE        = 1024;
    localparam int N          = 4;
    localparam int FEED_STEPS = 16;
    localparam int K_W        = 5;

    localparam logic signed [IN_W-1:0] ONE_Q = IN_W'(ONE);

    typedef struct packed {
        logic signed [IN_W-1:0] r;
        logic signed [IN_W-1:0] i;
    } cplx_t;

    typedef enum logic {
        LOAD = 1'b0,
        FEED = 1'b1
    } state_t;

endpackage

// File: rtl/qrd_in_lane.sv
// One skewed row lane: picks element A[ROW][k-ROW] of the identity-augmented matrix [H | I],
// or zero outside that row's eight-step window.
module qrd_in_lane
    import qrd_pkg::*;
#(
    parameter int ROW = 0
) (
    input  logic [K_W-1:0]  k,
    input  cplx_t [N-1:0]   h,
    output cplx_t           elem
);

    localparam logic [K_W-1:0] LO   = K_W'(ROW);
    localparam logic [K_W-1:0] HI   = K_W'(ROW + 2 * N);
    localparam logic [1:0]     DIAG = 2'(ROW);

    logic [K_W-1:0] col;

    always_comb begin
        elem = '0;
        col  = k - LO;
        if (k >= LO && k < HI) begin
            if (col < K_W'(N)) begin
                elem = h[col[1:0]];
            end else if (col[1:0] == DIAG) begin
                elem.r = ONE_Q;
            end
        end
    end

endmodule

// File: rtl/qrd_in_skew.sv
// Buffers one 4x4 complex channel matrix from a valid/ready stream, then feeds the QRD
// core its four skewed, identity-augmented row inputs, advancing only on in_ready.
module qrd_in_skew
    import qrd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [IN_W-1:0] s_r,
    input  logic signed [IN_W-1:0] s_i,
    input  logic                   s_last,
    input  logic                   in_ready,
    output logic signed [IN_W-1:0] row_in_1_r,
    output logic signed [IN_W-1:0] row_in_1_i,
    output logic signed [IN_W-1:0] row_in_2_r,
    output logic signed [IN_W-1:0] row_in_2_i,
    output logic signed [IN_W-1:0] row_in_3_r,
    output logic signed [IN_W-1:0] row_in_3_i,
    output logic signed [IN_W-1:0] row_in_4_r,
    output logic signed [IN_W-1:0] row_in_4_i,
    output logic                   row_in_1_f,
    output logic                   row_in_2_f,
    output logic                   row_in_3_f,
    output logic                   busy,
    output logic                   err
);

    localparam logic [3:0]     PTR_END = 4'(N * N - 1);
    localparam logic [K_W-1:0] K_END   = K_W'(FEED_STEPS);

    state_t         state;
    logic [3:0]     ptr;
    logic [K_W-1:0] k;
    cplx_t          hbuf [N*N];
    cplx_t          lane_out [N];
    cplx_t          row_q [N];
    logic [2:0]     flag_q;

    assign s_ready = (state == LOAD);
    assign busy    = (state == FEED);

    // Buffer holds only data; framing and reset are handled through ptr/state.
    always_ff @(posedge clk) begin
        if (rst_n && state == LOAD && s_valid) begin
            hbuf[ptr] <= {s_r, s_i};
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        cplx_t [N-1:0] h_row;
        for (genvar c = 0; c < N; c++) begin : g_col
            assign h_row[c] = hbuf[N*g + c];
        end
        qrd_in_lane #(.ROW(g)) u_lane (
            .k    (k),
            .h    (h_row),
            .elem (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= LOAD;
            ptr    <= '0;
            k      <= '0;
            err    <= 1'b0;
            flag_q <= '0;
            for (int r = 0; r < N; r++) row_q[r] <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        if (s_last != (ptr == PTR_END)) begin
                            err <= 1'b1;
                            ptr <= '0;
                        end else if (s_last) begin
                            state <= FEED;
                            ptr   <= '0;
                            k     <= '0;
                        end else begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                FEED: begin
                    // k == FEED_STEPS means step 15 has loaded; leave regardless of in_ready.
                    if (k == K_END) begin
                        state  <= LOAD;
                        k      <= '0;
                        flag_q <= '0;
                        for (int r = 0; r < N; r++) row_q[r] <= '0;
                    end else if (in_ready) begin
                        for (int r = 0; r < N; r++) row_q[r] <= lane_out[r];
                        flag_q <= {k == K_W'(4), k == K_W'(2), k == K_W'(0)};
                        k      <= k + K_W'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign row_in_1_r = row_q[0].r;
    assign row_in_1_i = row_q[0].i;
    assign row_in_2_r = row_q[1].r;
    assign row_in_2_i = row_q[1].i;
    assign row_in_3_r = row_q[2].r;
    assign row_in_3_i = row_q[2].i;
    assign row_in_4_r = row_q[3].r;
    assign row_in_4_i = row_q[3].i;
    assign row_in_1_f = flag_q[0];
    assign row_in_2_f = flag_q[1];
    assign row_in_3_f = flag_q[2];

endmodule
